// File: rtl/pwm_capture_pkg.sv
// Shared PWM definitions: capture FSM encoding, synchronizer depth default,
// and the counter widths of the companion PWM generator.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } cap_state_e;

    localparam int SYNC_STAGES_DEF = 2;

    // Generator counter widths, kept here so loopback setups agree on ranges
    localparam int GEN_TOP_WIDTH = 8;
    localparam int GEN_CMP_WIDTH = 8;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input followed by a registered
// edge detector; reusable by any block that samples a slow external level.
module sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_r;
    logic              sync_s;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    assign sync_s = sync_r[STAGES-1];

    // Synchronizer chain, previous-sample register and registered edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_s;
            rise_r <= sync_s & ~prev_r;
            fall_r <= ~sync_s & prev_r;
        end
    end

    // level tracks the sample the edge pulses were derived from
    assign level = prev_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement with saturation timeout; all results are
// registered and refer to the last complete rising-to-rising period.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_level
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             level_s;
    logic             rise_s;
    logic             fall_s;
    logic             cnt_sat_s;

    cap_state_e       state_r;
    cap_state_e       state_next_s;
    logic [WIDTH-1:0] counter_r;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] high_next_s;
    logic [WIDTH-1:0] period_next_s;
    logic [WIDTH-1:0] high_out_next_s;
    logic             valid_next_s;
    logic             timeout_next_s;

    // Restart at 1 on a rise so that edges k cycles apart measure exactly k
    function automatic logic [WIDTH-1:0] cnt_step(input logic [WIDTH-1:0] cnt,
                                                  input logic             restart);
        logic [WIDTH-1:0] nxt;
        if (restart) begin
            nxt = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
            nxt = cnt;
        end else begin
            nxt = cnt + CNT_ONE;
        end
        return nxt;
    endfunction

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (i_clk),
        .rst   (i_rst),
        .din   (i_pwm),
        .level (level_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign cnt_sat_s = (counter_r == CNT_MAX);

    // FSM state, free-running cycle counter and latched high time
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            counter_r <= {WIDTH{1'b0}};
            high_r    <= {WIDTH{1'b0}};
        end else begin
            state_r   <= state_next_s;
            counter_r <= cnt_step(counter_r, rise_s);
            high_r    <= high_next_s;
        end
    end

    // Next-state and next-output decode; a rise always beats saturation
    always_comb begin
        state_next_s    = state_r;
        high_next_s     = high_r;
        period_next_s   = o_period;
        high_out_next_s = o_high;
        valid_next_s    = 1'b0;
        timeout_next_s  = o_timeout;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next_s = ST_HIGH;
                end else if (cnt_sat_s) begin
                    timeout_next_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (rise_s) begin
                    // Missed fall: restart the period without reporting it
                    state_next_s = ST_HIGH;
                end else if (fall_s) begin
                    state_next_s = ST_LOW;
                    high_next_s  = counter_r;
                end else if (cnt_sat_s) begin
                    state_next_s   = ST_IDLE;
                    timeout_next_s = 1'b1;
                end else begin
                    state_next_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_next_s    = ST_HIGH;
                    period_next_s   = counter_r;
                    high_out_next_s = high_r;
                    valid_next_s    = 1'b1;
                    timeout_next_s  = 1'b0;
                end else if (cnt_sat_s) begin
                    state_next_s   = ST_IDLE;
                    timeout_next_s = 1'b1;
                end else begin
                    state_next_s = ST_LOW;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_period  <= {WIDTH{1'b0}};
            o_high    <= {WIDTH{1'b0}};
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_level   <= 1'b0;
        end else begin
            o_period  <= period_next_s;
            o_high    <= high_out_next_s;
            o_valid   <= valid_next_s;
            o_timeout <= timeout_next_s;
            o_level   <= level_s;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench: two instances (16-bit/2-stage and 8-bit/3-stage) driven
// by tables, random waveforms and directed reset/timeout sequences.
module tb_pwm_capture;

    localparam int LAT_A = 3;   // sync stages + 1
    localparam int LAT_B = 4;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 255;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic pwm_a = 1'b0;
    logic pwm_b = 1'b0;

    logic [15:0] per_a, high_a;
    logic        valid_a, to_a, lvl_a;
    logic [7:0]  per_b, high_b;
    logic        valid_b, to_b, lvl_b;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct { int due; int per; int hi; } exp_t;
    typedef struct { int h; int l; int n; int exp_per; int exp_hi; } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   last_rise[2];
    int   last_fall[2];
    bit   have_prev[2];
    bit   cur[2];

    pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_pwm(pwm_a),
        .o_period(per_a), .o_high(high_a), .o_valid(valid_a),
        .o_timeout(to_a), .o_level(lvl_a)
    );

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_pwm(pwm_b),
        .o_period(per_b), .o_high(high_b), .o_valid(valid_b),
        .o_timeout(to_b), .o_level(lvl_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Drive a level for n cycles starting at a negedge; the reference model
    // turns each sampled rising edge into an expected report (time, period, high).
    task automatic drive(input int sel, input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            if (b != cur[sel]) begin
                int edge_c;
                int lat;
                int maxp;
                edge_c = cyc + 1;
                lat    = (sel == 0) ? LAT_A : LAT_B;
                maxp   = (sel == 0) ? MAX_A : MAX_B;
                if (b) begin
                    if (have_prev[sel] && (edge_c - last_rise[sel]) <= maxp) begin
                        exp_t e;
                        e.due = edge_c + lat;
                        e.per = edge_c - last_rise[sel];
                        e.hi  = last_fall[sel] - last_rise[sel];
                        if (sel == 0) q_a.push_back(e);
                        else          q_b.push_back(e);
                    end
                    last_rise[sel] = edge_c;
                    have_prev[sel] = 1'b1;
                end else begin
                    last_fall[sel] = edge_c;
                end
                cur[sel] = b;
                if (sel == 0) pwm_a = b;
                else          pwm_b = b;
            end
            @(negedge clk);
        end
    endtask

    // Scoreboard for instance A
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a) begin
                if (q_a.size() == 0) begin
                    report_fail("a_unexpected_valid", $sformatf("got o_valid=1 period=%0d expected no pulse", per_a));
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_valid_time", cyc, e.due);
                    check("a_period", per_a, e.per);
                    check("a_high", high_a, e.hi);
                    check("a_timeout_at_valid", to_a, 0);
                end
            end else if (q_a.size() != 0 && q_a[0].due < cyc) begin
                check("a_missing_valid", cyc, q_a[0].due);
                void'(q_a.pop_front());
            end
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_b) begin
                if (q_b.size() == 0) begin
                    report_fail("b_unexpected_valid", $sformatf("got o_valid=1 period=%0d expected no pulse", per_b));
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("b_valid_time", cyc, e.due);
                    check("b_period", per_b, e.per);
                    check("b_high", high_b, e.hi);
                    check("b_timeout_at_valid", to_b, 0);
                end
            end else if (q_b.size() != 0 && q_b[0].due < cyc) begin
                check("b_missing_valid", cyc, q_b[0].due);
                void'(q_b.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        bit   found;
        int   h;
        int   l;

        tbl[0] = '{3,   7,   5, 10,  3};
        tbl[1] = '{1,   1,   6, 2,   1};
        tbl[2] = '{128, 128, 3, 256, 128};
        tbl[3] = '{5,   15,  3, 20,  5};
        tbl[4] = '{2,   9,   3, 11,  2};

        for (int s = 0; s < 2; s++) begin
            last_rise[s] = 0;
            last_fall[s] = 0;
            have_prev[s] = 1'b0;
            cur[s]       = 1'b0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_a_period", per_a, 0);
        check("rst_a_high", high_a, 0);
        check("rst_a_valid", valid_a, 0);
        check("rst_a_timeout", to_a, 0);
        check("rst_a_level", lvl_a, 0);
        check("rst_b_period", per_b, 0);
        check("rst_b_timeout", to_b, 0);
        rst = 1'b0;

        // Constant low from reset: B must time out with level 0
        repeat (100) @(negedge clk);
        check("b_idle_no_early_timeout", to_b, 0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (to_b) found = 1'b1;
        end
        check("b_idle_timeout_seen", found, 1);
        check("b_idle_level", lvl_b, 0);
        check("a_no_timeout", to_a, 0);

        // Table-driven steady waveforms on A
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < tbl[t].n; k++) begin
                drive(0, 1'b1, tbl[t].h);
                drive(0, 1'b0, tbl[t].l);
            end
            drive(0, 1'b1, LAT_A + 2);
            check($sformatf("tbl%0d_period", t), per_a, tbl[t].exp_per);
            check($sformatf("tbl%0d_high", t), high_a, tbl[t].exp_hi);
            check($sformatf("tbl%0d_timeout", t), to_a, 0);
            check($sformatf("tbl%0d_level", t), lvl_a, 1);
            drive(0, 1'b0, 3);
        end

        // Random waveforms on A against the model
        for (int k = 0; k < 40; k++) begin
            h = $urandom_range(20, 1);
            l = $urandom_range(20, 1);
            drive(0, 1'b1, h);
            drive(0, 1'b0, l);
        end
        drive(0, 1'b1, LAT_A + 2);
        drive(0, 1'b0, 3);
        check("a_random_queue_drained", q_a.size(), 0);

        // Reset in the middle of a high phase
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 3);
            drive(0, 1'b0, 7);
        end
        drive(0, 1'b1, 5);
        check("a_pre_reset_period", per_a, 10);
        check("a_pre_reset_level", lvl_a, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_a_period", per_a, 0);
        check("mid_rst_a_high", high_a, 0);
        check("mid_rst_a_valid", valid_a, 0);
        check("mid_rst_a_timeout", to_a, 0);
        check("mid_rst_a_level", lvl_a, 0);
        check("mid_rst_b_timeout", to_b, 0);
        q_a.delete();
        q_b.delete();
        have_prev[0] = 1'b0;
        have_prev[1] = 1'b0;
        @(negedge clk);
        drive(0, 1'b0, 4);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 3);
            drive(0, 1'b0, 7);
        end
        drive(0, 1'b1, LAT_A + 2);
        check("a_post_reset_period", per_a, 10);
        check("a_post_reset_high", high_a, 3);
        drive(0, 1'b0, 3);

        // B: measured periods, then a single rise held high until timeout
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 5);
            drive(1, 1'b0, 15);
        end
        drive(1, 1'b1, 200);
        check("b_hold_no_early_timeout", to_b, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            drive(1, 1'b1, 1);
            if (to_b) found = 1'b1;
        end
        check("b_hold_timeout_seen", found, 1);
        check("b_hold_level", lvl_b, 1);
        check("b_hold_period_kept", per_b, 20);
        check("b_hold_high_kept", high_b, 5);

        // Resume: the first rise must not clear the timeout
        drive(1, 1'b0, 15);
        drive(1, 1'b1, 5);
        check("b_timeout_after_first_rise", to_b, 1);
        drive(1, 1'b0, 15);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1'b1, 5);
            drive(1, 1'b0, 15);
        end
        drive(1, 1'b1, LAT_B + 2);
        check("b_resume_timeout_clear", to_b, 0);
        check("b_resume_period", per_b, 20);
        check("b_resume_high", high_b, 5);
        drive(1, 1'b0, 6);

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
